param_adder_accum: RTL

- Parameterised, handshaked arithmetic core; successor to the combinational doubling adder.
- Adds WIDTH generalisation, four operation modes, a running accumulator, optional saturation, and carry/overflow reporting.
- Registered output with a valid/ready handshake; sustains one operation per cycle.
- Instantiated behind the Tiny Tapeout pin wrapper: ui_in/uio_in drive operands, uo_out carries the result.

---
 rtl/param_adder_accum.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/param_adder_accum.sv
// param_adder_accum: handshaked WIDTH-bit arithmetic core (ADD/SUB/ACC/DBL)
// with a running accumulator, optional saturation, raw carry/borrow
// reporting and a sticky overflow flag. One-entry registered output stage.
//
// Output stage state table:
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_EMPTY | no unconsumed result, core accepts unconditionally
//   ST_FULL  | result/carry hold a result not yet taken downstream

module param_adder_accum #(
   parameter int   WIDTH       = 8,
   parameter logic SAT_DEFAULT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   input  logic             sat_wr,
   input  logic             sat_val,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf_sticky
);

   localparam logic [1:0] MODE_ADD = 2'd0;
   localparam logic [1:0] MODE_SUB = 2'd1;
   localparam logic [1:0] MODE_ACC = 2'd2;
   localparam logic [1:0] MODE_DBL = 2'd3;

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   logic             state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             sat_en_q, sat_en_d;

   logic             accept;
   logic [WIDTH-1:0] acc_eff;
   logic [WIDTH:0]   sum_w;
   logic             raw_carry;
   logic [WIDTH-1:0] op_res;

   assign out_valid  = (state_q == ST_FULL);
   assign in_ready   = !out_valid || out_ready;
   assign accept     = in_valid && in_ready;
   assign result     = result_q;
   assign carry      = carry_q;
   assign ovf_sticky = ovf_sticky_q;

   // Datapath: WIDTH+1-bit arithmetic, raw carry/borrow, then optional clamp.
   // A same-cycle acc_clr makes the accumulate start from zero.
   always_comb begin
      acc_eff   = acc_clr ? '0 : acc_q;
      sum_w     = '0;
      raw_carry = 1'b0;
      case (mode)
         MODE_ADD: begin
            sum_w     = {1'b0, a} + {1'b0, b};
            raw_carry = sum_w[WIDTH];
         end
         MODE_SUB: begin
            sum_w     = {1'b0, a} - {1'b0, b};
            raw_carry = (a < b);
         end
         MODE_ACC: begin
            sum_w     = {1'b0, acc_eff} + {1'b0, a};
            raw_carry = sum_w[WIDTH];
         end
         default: begin
            sum_w     = {a, 1'b0};
            raw_carry = a[WIDTH-1];
         end
      endcase
      op_res = sum_w[WIDTH-1:0];
      if (sat_en_q && raw_carry) begin
         op_res = (mode == MODE_SUB) ? '0 : '1;
      end
   end

   // Next-state for the output stage, accumulator, sticky flag and sat enable.
   always_comb begin
      state_d      = state_q;
      result_d     = result_q;
      carry_d      = carry_q;
      acc_d        = acc_q;
      ovf_sticky_d = ovf_sticky_q;
      sat_en_d     = sat_en_q;

      if (accept) begin
         state_d  = ST_FULL;
         result_d = op_res;
         carry_d  = raw_carry;
      end else if (out_ready) begin
         state_d  = ST_EMPTY;
      end

      if (accept && (mode == MODE_ACC)) begin
         acc_d = op_res;
      end else if (acc_clr) begin
         acc_d = '0;
      end

      // A carrying accept wins over a simultaneous clear.
      if (accept && raw_carry) begin
         ovf_sticky_d = 1'b1;
      end else if (acc_clr) begin
         ovf_sticky_d = 1'b0;
      end

      if (sat_wr) begin
         sat_en_d = sat_val;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         result_q     <= '0;
         carry_q      <= 1'b0;
         acc_q        <= '0;
         ovf_sticky_q <= 1'b0;
         sat_en_q     <= SAT_DEFAULT;
      end else begin
         state_q      <= state_d;
         result_q     <= result_d;
         carry_q      <= carry_d;
         acc_q        <= acc_d;
         ovf_sticky_q <= ovf_sticky_d;
         sat_en_q     <= sat_en_d;
      end
   end

endmodule
